pipe_stall_ctrl: RTL and testbench

Central stall/flush sequencer for the 5-stage pipelined core. It merges the per-cycle hazard sources into one consistent set of pipeline-register enables and bubble-inserts:
- the load-use stall request from hazard detection
- the EX-stage branch/jump redirect
- instruction-fetch wait
- data-memory wait
- multi-cycle mul/div occupancy

A small FSM tracks the multi-cycle conditions. Two wrap-around performance counters expose stall and flush activity.

---
 rtl/pipe_stall_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage core: merges hazard sources into
// pipeline-register enables and bubble-inserts, plus stall/flush perf counters.
module pipe_stall_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_use,
  input  logic             branch_taken,
  input  logic             imem_ready,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  input  logic             md_start,
  input  logic             md_done,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             idex_write,
  output logic             exmem_write,
  output logic             memwb_write,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             md_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    ST_INIT     = 2'd0,
    ST_RUN      = 2'd1,
    ST_MD_WAIT  = 2'd2,
    ST_MEM_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state_q, state_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             mem_stall;
  logic             run_decide;
  logic             stall_inc, flush_inc;

  assign mem_stall = dmem_req & ~dmem_ready;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_write  = 1'b1;
    exmem_write = 1'b1;
    memwb_write = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    state_d     = state_q;
    done_d      = done_q;
    run_decide  = 1'b0;
    flush_inc   = 1'b0;

    case (state_q)
      ST_INIT: begin
        pc_write    = 1'b0;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
        exmem_flush = 1'b1;
        state_d     = ST_RUN;
      end
      ST_RUN: run_decide = 1'b1;
      ST_MEM_WAIT: begin
        if (!dmem_ready) begin
          {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = '0;
        end else begin
          run_decide = 1'b1;
        end
      end
      ST_MD_WAIT: begin
        if (mem_stall) begin
          {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = '0;
          done_d = done_q | md_done;
        end else if (md_done || done_q) begin
          done_d  = 1'b0;
          state_d = ST_RUN;
        end else begin
          pc_write    = 1'b0;
          ifid_write  = 1'b0;
          idex_write  = 1'b0;
          exmem_flush = 1'b1;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // Shared by RUN and the MEM_WAIT release cycle; mem_stall is always 0 on the latter.
    if (run_decide) begin
      state_d = ST_RUN;
      if (mem_stall) begin
        {pc_write, ifid_write, idex_write, exmem_write, memwb_write} = '0;
        state_d = ST_MEM_WAIT;
      end else if (md_start) begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        idex_write  = 1'b0;
        exmem_flush = 1'b1;
        done_d      = 1'b0;
        state_d     = ST_MD_WAIT;
      end else if (branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_inc  = 1'b1;
      end else if (load_use) begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_flush = 1'b1;
      end else if (!imem_ready) begin
        pc_write   = 1'b0;
        ifid_flush = 1'b1;
      end
    end
  end

  assign stall_inc    = ~pc_write & (state_q != ST_INIT);
  assign md_busy      = (state_q == ST_MD_WAIT);
  assign stall_cycles = stall_q;
  assign flush_events = flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      done_q  <= 1'b0;
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      if (stall_inc) stall_q <= stall_q + CNT_ONE;
      if (flush_inc) flush_q <= flush_q + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Directed bench for pipe_stall_ctrl: expected outputs/counters are queued per
// step and compared against a 32-bit and a 4-bit-counter instance.
module tb_pipe_stall_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic load_use, branch_taken, imem_ready, dmem_req, dmem_ready, md_start, md_done;

  logic pc_a, ifw_a, idw_a, exw_a, mww_a, iff_a, idf_a, exf_a, busy_a;
  logic pc_b, ifw_b, idw_b, exw_b, mww_b, iff_b, idf_b, exf_b, busy_b;
  logic [31:0] st_a, fl_a;
  logic [3:0]  st_b, fl_b;
  logic [8:0]  o_a, o_b;

  int checks = 0;
  int errors = 0;
  logic [31:0] st_m = '0;
  logic [31:0] fl_m = '0;

  typedef struct {
    logic [8:0]  o;
    logic [31:0] st;
    logic [31:0] fl;
    string       tag;
  } exp_t;
  exp_t sb[$];

  // Output vector: {pc, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, exmem_f, md_busy}
  localparam logic [8:0] O_INIT = 9'b0_1111_111_0;
  localparam logic [8:0] O_DEF  = 9'b1_1111_000_0;
  localparam logic [8:0] O_LU   = 9'b0_0111_010_0;
  localparam logic [8:0] O_BR   = 9'b1_1111_110_0;
  localparam logic [8:0] O_IM   = 9'b0_1111_100_0;
  localparam logic [8:0] O_MDS  = 9'b0_0011_001_0;
  localparam logic [8:0] O_MDW  = 9'b0_0011_001_1;
  localparam logic [8:0] O_MDX  = 9'b1_1111_000_1;
  localparam logic [8:0] O_FRZ  = 9'b0_0000_000_0;
  localparam logic [8:0] O_FRZB = 9'b0_0000_000_1;

  // Input vector: {load_use, branch_taken, imem_ready, dmem_req, dmem_ready, md_start, md_done}
  localparam logic [6:0] I_IDLE   = 7'b0010000;
  localparam logic [6:0] I_JUNK   = 7'b1100011;
  localparam logic [6:0] I_LU     = 7'b1010000;
  localparam logic [6:0] I_BRX    = 7'b1100000;
  localparam logic [6:0] I_NOIM   = 7'b0000000;
  localparam logic [6:0] I_MS     = 7'b0010010;
  localparam logic [6:0] I_MSD    = 7'b0010011;
  localparam logic [6:0] I_MSMEM  = 7'b0011010;
  localparam logic [6:0] I_MSMEMD = 7'b0011011;
  localparam logic [6:0] I_MSRDY  = 7'b0011110;
  localparam logic [6:0] I_MEMST  = 7'b0011000;
  localparam logic [6:0] I_MEMBR  = 7'b0111100;
  localparam logic [6:0] I_MEMLU  = 7'b1011100;

  pipe_stall_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .load_use(load_use), .branch_taken(branch_taken), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .md_start(md_start), .md_done(md_done),
    .pc_write(pc_a), .ifid_write(ifw_a), .idex_write(idw_a), .exmem_write(exw_a),
    .memwb_write(mww_a), .ifid_flush(iff_a), .idex_flush(idf_a), .exmem_flush(exf_a),
    .md_busy(busy_a), .stall_cycles(st_a), .flush_events(fl_a)
  );

  pipe_stall_ctrl #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .load_use(load_use), .branch_taken(branch_taken), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_ready(dmem_ready), .md_start(md_start), .md_done(md_done),
    .pc_write(pc_b), .ifid_write(ifw_b), .idex_write(idw_b), .exmem_write(exw_b),
    .memwb_write(mww_b), .ifid_flush(iff_b), .idex_flush(idf_b), .exmem_flush(exf_b),
    .md_busy(busy_b), .stall_cycles(st_b), .flush_events(fl_b)
  );

  assign o_a = {pc_a, ifw_a, idw_a, exw_a, mww_a, iff_a, idf_a, exf_a, busy_a};
  assign o_b = {pc_b, ifw_b, idw_b, exw_b, mww_b, iff_b, idf_b, exf_b, busy_b};

  always #5 clk = ~clk;

  task automatic drive(input logic [6:0] in);
    {load_use, branch_taken, imem_ready, dmem_req, dmem_ready, md_start, md_done} = in;
  endtask

  // One clock cycle: drive, queue expectation, compare at negedge, advance past posedge.
  task automatic step(input string tag, input logic [6:0] in, input logic [8:0] exp,
                      input bit init, input bit br);
    exp_t e;
    drive(in);
    e.o = exp; e.st = st_m; e.fl = fl_m; e.tag = tag;
    sb.push_back(e);
    @(negedge clk);
    e = sb.pop_front();
    checks++;
    assert (o_a === e.o) else begin
      errors++; $error("FAIL %s out got %b exp %b", e.tag, o_a, e.o);
    end
    checks++;
    assert (o_b === e.o) else begin
      errors++; $error("FAIL %s out4 got %b exp %b", e.tag, o_b, e.o);
    end
    checks++;
    assert (st_a === e.st) else begin
      errors++; $error("FAIL %s stall got %0d exp %0d", e.tag, st_a, e.st);
    end
    checks++;
    assert (fl_a === e.fl) else begin
      errors++; $error("FAIL %s flush got %0d exp %0d", e.tag, fl_a, e.fl);
    end
    checks++;
    assert (st_b === e.st[3:0]) else begin
      errors++; $error("FAIL %s stall4 got %0d exp %0d", e.tag, st_b, e.st[3:0]);
    end
    checks++;
    assert (fl_b === e.fl[3:0]) else begin
      errors++; $error("FAIL %s flush4 got %0d exp %0d", e.tag, fl_b, e.fl[3:0]);
    end
    if (!init && !exp[8]) st_m = st_m + 1;
    if (br) fl_m = fl_m + 1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(I_JUNK);
    @(posedge clk); #1;

    // Reset held, inputs ignored
    step("rst0", I_JUNK, O_INIT, 1, 0);
    step("rst1", I_JUNK, O_INIT, 1, 0);
    step("rst2", I_JUNK, O_INIT, 1, 0);
    rst_n = 1'b1;
    step("init", I_JUNK, O_INIT, 1, 0);
    step("run_def", I_IDLE, O_DEF, 0, 0);

    // Single load-use bubble
    step("lu", I_LU, O_LU, 0, 0);
    step("lu_after", I_IDLE, O_DEF, 0, 0);

    // Branch beats load_use and fetch wait
    step("br_prio", I_BRX, O_BR, 0, 1);
    step("br_after", I_IDLE, O_DEF, 0, 0);

    step("imem_wait", I_NOIM, O_IM, 0, 0);
    step("imem_after", I_IDLE, O_DEF, 0, 0);

    // Mul/div, md_done 4 cycles after entering MD_WAIT
    step("md_start", I_MS, O_MDS, 0, 0);
    for (int i = 0; i < 4; i++) step("md_wait", I_MS, O_MDW, 0, 0);
    step("md_exit", I_MSD, O_MDX, 0, 0);
    step("md_after", I_IDLE, O_DEF, 0, 0);

    // md_done during mem_stall is held in done_q
    step("mdm_start", I_MS, O_MDS, 0, 0);
    step("mdm_wait", I_MS, O_MDW, 0, 0);
    step("mdm_frz_done", I_MSMEMD, O_FRZB, 0, 0);
    step("mdm_frz", I_MSMEM, O_FRZB, 0, 0);
    step("mdm_exit", I_MSRDY, O_MDX, 0, 0);
    step("mdm_after", I_IDLE, O_DEF, 0, 0);

    // RUN -> MEM_WAIT, release with branch
    step("mem_enter", I_MEMST, O_FRZ, 0, 0);
    step("mem_hold", I_MEMST, O_FRZ, 0, 0);
    step("mem_rel_br", I_MEMBR, O_BR, 0, 1);
    step("mem_after", I_IDLE, O_DEF, 0, 0);

    // MEM_WAIT release with load_use
    step("mem2_enter", I_MEMST, O_FRZ, 0, 0);
    step("mem2_rel_lu", I_MEMLU, O_LU, 0, 0);
    step("mem2_after", I_IDLE, O_DEF, 0, 0);

    // Drive stall count to 17 so the 4-bit counter wraps to 1
    while (st_m < 17) step("lu_wrap", I_LU, O_LU, 0, 0);
    step("wrap_chk", I_IDLE, O_DEF, 0, 0);

    // Reset in MD_WAIT with a pending md_done in done_q
    step("mdr_start", I_MS, O_MDS, 0, 0);
    step("mdr_wait", I_MS, O_MDW, 0, 0);
    step("mdr_frz_done", I_MSMEMD, O_FRZB, 0, 0);
    rst_n = 1'b0;
    st_m = '0;
    fl_m = '0;
    step("mdr_rst", I_MSMEM, O_INIT, 1, 0);
    rst_n = 1'b1;
    step("mdr_init", I_IDLE, O_INIT, 1, 0);
    step("mdr_def", I_IDLE, O_DEF, 0, 0);
    step("mdr2_start", I_MS, O_MDS, 0, 0);
    step("mdr2_nodone", I_MS, O_MDW, 0, 0);
    step("mdr2_exit", I_MSD, O_MDX, 0, 0);
    step("mdr2_after", I_IDLE, O_DEF, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
